// File: rtl/prim_mubi_pkg.sv
// prim_mubi_pkg: multi-bit boolean encodings shared across the ROM controller
package prim_mubi_pkg;
  typedef enum logic [3:0] {
    MuBi4True  = 4'h6,
    MuBi4False = 4'h9
  } mubi4_t;
endpackage

// File: rtl/rom_ctrl_chk_pkg.sv
// rom_ctrl_chk_pkg: sparse FSM encoding and alert-cause indices for the checker reader
package rom_ctrl_chk_pkg;
  localparam int StateWidth = 5;
  typedef enum logic [StateWidth-1:0] {
    Idle       = 5'b01101,
    Reading    = 5'b10011,
    WaitDigest = 5'b00110,
    Done       = 5'b11000,
    Invalid    = 5'b10101
  } state_e;
  localparam int AlertDoneEarly = 0;
  localparam int AlertAddr      = 1;
  localparam int AlertOverflow  = 2;
  localparam int AlertState     = 3;
  localparam int NumAlertCauses = 4;
endpackage

// File: rtl/prim_fifo_sync.sv
// prim_fifo_sync: synchronous valid/ready FIFO with optional empty pass-through
module prim_fifo_sync #(
  parameter int Width = 16,
  parameter bit Pass  = 1'b1,
  parameter int Depth = 4,
  localparam int PW   = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int CW   = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  input  logic [Width-1:0] wdata_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o,
  output logic [CW-1:0]    depth_o
);
  logic [Width-1:0] mem [Depth];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic empty, full, push, pop;
  assign empty    = cnt == '0;
  assign full     = cnt == CW'(Depth);
  assign wready_o = ~full;
  assign rvalid_o = ~empty | (Pass & wvalid_i);
  assign rdata_o  = (Pass && empty) ? wdata_i : mem[rptr];
  assign push     = wvalid_i & ~full & ~(Pass & empty & rready_i);
  assign pop      = rready_i & ~empty;
  assign depth_o  = cnt;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (clr_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata_i;
        wptr      <= (wptr == PW'(Depth - 1)) ? '0 : wptr + 1'b1;
      end
      if (pop) rptr <= (rptr == PW'(Depth - 1)) ? '0 : rptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/prim_sparse_fsm_flop.sv
// prim_sparse_fsm_flop: state register for sparsely encoded FSMs
module prim_sparse_fsm_flop #(
  parameter int               Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] state_i,
  output logic [Width-1:0] state_o
);
  logic [Width-1:0] state_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= ResetValue;
    else state_q <= state_i;
  assign state_o = state_q;
endmodule

// File: rtl/rom_ctrl_chk_reader.sv
// rom_ctrl_chk_reader: sweeps the ROM through the checker port into the digest stream
module rom_ctrl_chk_reader
  import rom_ctrl_chk_pkg::*;
  import prim_mubi_pkg::*;
#(
  parameter int AW       = 8,
  parameter int DW       = 39,
  parameter int RomDepth = 256
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  output logic [AW-1:0] chk_addr_o,
  output logic          chk_req_o,
  input  logic [DW-1:0] chk_rdata_i,
  output logic          data_valid_o,
  output logic [DW-1:0] data_o,
  output logic          data_last_o,
  input  logic          data_ready_i,
  input  logic          digest_done_i,
  output mubi4_t        sel_bus_o,
  output logic          alert_o
);
  localparam logic [AW:0] DepthW   = (AW + 1)'(RomDepth);
  localparam logic [AW:0] LastAddr = (AW + 1)'(RomDepth - 1);
  logic [StateWidth-1:0] state_d, state_q;
  logic [AW:0] addr_d, addr_q;
  logic req_q, last_q, alert_q, fifo_wready, fifo_rvalid, pop, hs_last, credit_ok;
  logic [NumAlertCauses-1:0] cause;
  logic [1:0] fifo_depth;
  logic [DW:0] fifo_rdata;
  mubi4_t sel_d, sel_q;
  assign pop       = fifo_rvalid & data_ready_i;
  assign hs_last   = pop & fifo_rdata[DW];
  assign credit_ok = ({1'b0, fifo_depth} + {2'b0, req_q}) < (3'd2 + {2'b0, pop});
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    chk_req_o = 1'b0;
    cause     = '0;
    case (state_q)
      Idle: begin
        cause[AlertDoneEarly] = digest_done_i;
        if (start_i) begin
          state_d = Reading;
          addr_d  = '0;
        end
      end
      Reading: begin
        cause[AlertDoneEarly] = digest_done_i;
        cause[AlertAddr]      = addr_q > DepthW;
        chk_req_o             = (addr_q < DepthW) && credit_ok;
        addr_d                = addr_q + (AW + 1)'(chk_req_o);
        if (hs_last) state_d = WaitDigest;
      end
      WaitDigest: if (digest_done_i) begin
        state_d = Done;
        sel_d   = MuBi4True;
      end
      Done: ;
      default: cause[AlertState] = 1'b1;
    endcase
    cause[AlertOverflow] = req_q & ~fifo_wready;
    // any fault freezes the sweep and the bus grant where they stand
    if (|cause) begin
      state_d   = Invalid;
      addr_d    = addr_q;
      sel_d     = sel_q;
      chk_req_o = 1'b0;
    end
  end
  prim_sparse_fsm_flop #(
    .Width      (StateWidth),
    .ResetValue (Idle)
  ) u_state_regs (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .state_i (state_d),
    .state_o (state_q)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      addr_q  <= '0;
      req_q   <= 1'b0;
      last_q  <= 1'b0;
      sel_q   <= MuBi4False;
      alert_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      req_q   <= chk_req_o;
      last_q  <= chk_req_o && (addr_q == LastAddr);
      sel_q   <= sel_d;
      alert_q <= alert_q | (|cause);
    end
  prim_fifo_sync #(
    .Width (DW + 1),
    .Pass  (1'b0),
    .Depth (2)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (1'b0),
    .wvalid_i (req_q),
    .wready_o (fifo_wready),
    .wdata_i  ({last_q, chk_rdata_i}),
    .rvalid_o (fifo_rvalid),
    .rready_i (data_ready_i),
    .rdata_o  (fifo_rdata),
    .depth_o  (fifo_depth)
  );
  assign chk_addr_o   = addr_q[AW-1:0];
  assign data_valid_o = fifo_rvalid;
  assign data_o       = fifo_rdata[DW-1:0];
  assign data_last_o  = fifo_rvalid & fifo_rdata[DW];
  assign sel_bus_o    = sel_q;
  assign alert_o      = alert_q;
endmodule

// File: tb/tb_rom_ctrl_chk_reader.sv
// tb_rom_ctrl_chk_reader: directed and randomized checks of the ROM checker reader
module tb_rom_ctrl_chk_reader;
  import prim_mubi_pkg::*;
  localparam int AW = 8;
  localparam int DW = 39;
  localparam int D  = 4;
  logic clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0, data_ready_i = 1'b0, digest_done_i = 1'b0;
  logic [DW-1:0] chk_rdata_i = '0;
  logic [AW-1:0] chk_addr_o;
  logic chk_req_o, data_valid_o, data_last_o, alert_o;
  logic [DW-1:0] data_o;
  mubi4_t sel_bus_o;
  int total = 0, bad = 0;
  logic [DW-1:0] rom [D];
  int issued, popped, c;
  logic stall_q;
  logic [DW-1:0] hold_q;

  rom_ctrl_chk_reader #(.AW(AW), .DW(DW), .RomDepth(D)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .chk_addr_o    (chk_addr_o),
    .chk_req_o     (chk_req_o),
    .chk_rdata_i   (chk_rdata_i),
    .data_valid_o  (data_valid_o),
    .data_o        (data_o),
    .data_last_o   (data_last_o),
    .data_ready_i  (data_ready_i),
    .digest_done_i (digest_done_i),
    .sel_bus_o     (sel_bus_o),
    .alert_o       (alert_o)
  );

  always #5 clk_i = ~clk_i;

  // ROM behind the mux: answers one cycle after a request, garbage otherwise
  always @(posedge clk_i)
    chk_rdata_i <= chk_req_o ? rom[chk_addr_o[1:0]] : DW'({$urandom(), $urandom()});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_rom();
    for (int i = 0; i < D; i++) rom[i] = DW'({$urandom(), $urandom()});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, chk_req_o, 0);
    chk({tag, "_addr"}, chk_addr_o, 0);
    chk({tag, "_valid"}, data_valid_o, 0);
    chk({tag, "_data"}, data_o, 0);
    chk({tag, "_last"}, data_last_o, 0);
    chk({tag, "_sel"}, sel_bus_o, MuBi4False);
    chk({tag, "_alert"}, alert_o, 0);
  endtask

  task automatic reset_dut(input string tag);
    rst_ni = 1'b0;
    start_i = 1'b0;
    data_ready_i = 1'b0;
    digest_done_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_reset(tag);
    rst_ni = 1'b1;
    issued = 0;
    popped = 0;
    stall_q = 1'b0;
    c = 0;
  endtask

  // drive one cycle's inputs and check the stream against the in-order ROM model
  task automatic cyc(input logic st, input logic rdy, input logic dn);
    start_i = st;
    data_ready_i = rdy;
    digest_done_i = dn;
    #1;
    if (chk_req_o) begin
      chk("req_addr", chk_addr_o, issued);
      issued++;
    end
    if (stall_q) begin
      chk("hold_valid", data_valid_o, 1);
      chk("hold_data", data_o, hold_q);
    end
    if (data_valid_o && rdy) begin
      chk("word_in_range", popped < D, 1);
      if (popped < D) begin
        chk("word_data", data_o, rom[popped]);
        chk("word_last", data_last_o, popped == D - 1);
      end
      popped++;
    end
    chk("outstanding", (issued - popped) <= 2, 1);
    stall_q = data_valid_o & ~rdy;
    hold_q = data_o;
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
    c++;
  endtask

  initial begin
    reset_dut("rst");

    new_rom();
    for (int i = 0; i <= 12; i++) begin
      cyc(i == 0, 1'b1, i == 10);
      chk("t_req", chk_req_o, i >= 1 && i <= 4);
      chk("t_valid", data_valid_o, i >= 3 && i <= 6);
      chk("t_last", data_last_o, i == 6);
      chk("t_sel", sel_bus_o, i >= 11 ? MuBi4True : MuBi4False);
      chk("t_alert", alert_o, 0);
      adv();
    end
    chk("t_all_words", popped, D);

    for (int i = 0; i < 4; i++) begin
      cyc(i == 0, 1'b1, i == 1);
      chk("done_req", chk_req_o, 0);
      chk("done_sel", sel_bus_o, MuBi4True);
      chk("done_alert", alert_o, 0);
      adv();
    end

    force dut.u_state_regs.state_q = 5'b00000;
    cyc(1'b0, 1'b0, 1'b0);
    chk("force_alert_pre", alert_o, 0);
    adv();
    release dut.u_state_regs.state_q;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      chk("force_alert", alert_o, 1);
      chk("force_sel", sel_bus_o, MuBi4True);
      chk("force_req", chk_req_o, 0);
      adv();
    end

    reset_dut("bp_rst");
    new_rom();
    for (int i = 0; i < 20; i++) begin
      cyc(i == 0, !(i >= 3 && i <= 8), 1'b0);
      adv();
    end
    chk("bp_all_words", popped, D);
    cyc(1'b0, 1'b1, 1'b1);
    adv();
    cyc(1'b0, 1'b1, 1'b0);
    chk("bp_sel", sel_bus_o, MuBi4True);
    chk("bp_alert", alert_o, 0);

    for (int r = 0; r < 3; r++) begin
      reset_dut("rnd_rst");
      new_rom();
      cyc(1'b1, 1'($urandom), 1'b0);
      adv();
      for (int i = 0; i < 60 && popped < D; i++) begin
        cyc(1'b0, 1'($urandom), 1'b0);
        adv();
      end
      chk("rnd_all_words", popped, D);
      chk("rnd_issued", issued, D);
      cyc(1'b0, 1'b1, 1'b1);
      adv();
      cyc(1'b0, 1'b1, 1'b0);
      chk("rnd_sel", sel_bus_o, MuBi4True);
      chk("rnd_alert", alert_o, 0);
    end

    reset_dut("early_rst");
    new_rom();
    cyc(1'b1, 1'b1, 1'b0);
    adv();
    cyc(1'b0, 1'b1, 1'b0);
    adv();
    cyc(1'b0, 1'b1, 1'b1);
    chk("early_alert_pre", alert_o, 0);
    adv();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      chk("early_alert", alert_o, 1);
      chk("early_sel", sel_bus_o, MuBi4False);
      chk("early_req", chk_req_o, 0);
      adv();
    end

    reset_dut("mid_rst");
    new_rom();
    for (int i = 0; i < 3; i++) begin
      cyc(i == 0, 1'b1, 1'b0);
      adv();
    end
    cyc(1'b0, 1'b1, 1'b0);
    chk("mid_req2", chk_req_o, 1);
    chk("mid_addr2", chk_addr_o, 2);
    rst_ni = 1'b0;
    #1;
    chk_reset("mid_async");
    reset_dut("mid_rst2");
    cyc(1'b1, 1'b1, 1'b0);
    chk("restart_idle_req", chk_req_o, 0);
    adv();
    cyc(1'b0, 1'b1, 1'b0);
    chk("restart_req", chk_req_o, 1);
    chk("restart_addr", chk_addr_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
